// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes, FSM encoding, counter width.
// The BREAK state exists only when UART_RX_BREAK_DETECT_EN is defined.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

`ifdef UART_RX_BREAK_DETECT_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`endif

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Serial input conditioning: 2-flop synchroniser, falling-edge detect, bit-period counter
// and 2-of-3 majority vote around mid-bit.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1041
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  input  logic run,
  output logic din_s,
  output logic fall_edge,
  output logic sample_strobe,
  output logic sample_bit,
  output logic bit_end
);

  localparam int CW   = cnt_width(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] C_S1   = CW'(HALF);
  localparam logic [CW-1:0] C_S2   = CW'(HALF + 1);

  logic          sync1, sync2, din_prev;
  logic [CW-1:0] cnt;
  logic          samp_a, samp_b;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      din_prev <= 1'b1;
      cnt      <= '0;
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
    end else begin
      sync1    <= din;
      sync2    <= sync1;
      din_prev <= sync2;
      // Counter is held at zero while idle so every frame starts aligned to its start edge.
      if (!run || cnt == C_LAST) cnt <= '0;
      else                       cnt <= cnt + CW'(1);
      if (run && cnt == C_S0) samp_a <= sync2;
      if (run && cnt == C_S1) samp_b <= sync2;
    end
  end

  assign din_s         = sync2;
  assign fall_edge     = din_prev & ~sync2;
  assign sample_strobe = run && (cnt == C_S2);
  assign sample_bit    = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);
  assign bit_end       = run && (cnt == C_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output and overrun pulse.
// Define UART_RX_BREAK_DETECT_EN to add break detection and the rx_break output.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1041,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 din,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_overrun,
  output logic                 rx_busy
`ifdef UART_RX_BREAK_DETECT_EN
  , output logic               rx_break
`endif
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  state_t               state;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_acc, ferr_acc, stop_zero, deliver;
  logic                 run, din_s, fall_edge, sample_strobe, sample_bit, bit_end;
  logic                 par_exp;

  assign run     = (state != ST_IDLE);
  assign rx_busy = run;
  assign par_exp = (PARITY_MODE == PAR_ODD) ? ~(^shreg) : ^shreg;

  uart_bit_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clock         (clock),
    .reset         (reset),
    .din           (din),
    .run           (run),
    .din_s         (din_s),
    .fall_edge     (fall_edge),
    .sample_strobe (sample_strobe),
    .sample_bit    (sample_bit),
    .bit_end       (bit_end)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      stop_zero  <= 1'b0;
      deliver    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_perr    <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_overrun <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      rx_break   <= 1'b0;
`endif
    end else begin
      rx_overrun <= 1'b0;
      deliver    <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      // A delivery arriving while the held word is unaccepted is dropped and flagged.
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_perr  <= perr_acc;
          rx_ferr  <= ferr_acc;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (fall_edge && !din_s) begin
            state     <= ST_START;
            bit_idx   <= '0;
            perr_acc  <= 1'b0;
            ferr_acc  <= 1'b0;
            stop_zero <= 1'b1;
          end
        end
        ST_START: begin
          if (sample_strobe && sample_bit) state <= ST_IDLE;
          else if (bit_end)                state <= ST_DATA;
        end
        ST_DATA: begin
          if (sample_strobe) begin
            shreg <= {sample_bit, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              state   <= (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (sample_strobe) begin
            perr_acc <= (sample_bit != par_exp);
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample_strobe) begin
            if (!sample_bit) ferr_acc  <= 1'b1;
            else             stop_zero <= 1'b0;
            if (bit_idx == LAST_STOP) begin
              // Leave at mid-bit of the last stop so a back-to-back start edge is not missed.
              state <= ST_IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
              if (shreg == '0 && stop_zero && !sample_bit) begin
                state    <= ST_BREAK;
                rx_break <= 1'b1;
              end else begin
                deliver <= 1'b1;
              end
`else
              deliver <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
`ifdef UART_RX_BREAK_DETECT_EN
        ST_BREAK: begin
          if (din_s) begin
            state    <= ST_IDLE;
            rx_break <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8E2 instance driven from a vector table plus
// hand-written sequences, and a 7O2 instance for the alternate configuration.
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din0 = 1'b1, din1 = 1'b1;
  logic       ready0 = 1'b1;
  logic [7:0] data0;
  logic [6:0] data1;
  logic       valid0, perr0, ferr0, ovr0, busy0;
  logic       valid1, perr1, ferr1, ovr1, busy1;
`ifdef UART_RX_BREAK_DETECT_EN
  logic       brk0, brk1;
`endif

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) dut0 (
    .clock(clk), .reset(rst_n), .din(din0), .rx_data(data0), .rx_valid(valid0),
    .rx_ready(ready0), .rx_perr(perr0), .rx_ferr(ferr0), .rx_overrun(ovr0), .rx_busy(busy0)
`ifdef UART_RX_BREAK_DETECT_EN
    , .rx_break(brk0)
`endif
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut1 (
    .clock(clk), .reset(rst_n), .din(din1), .rx_data(data1), .rx_valid(valid1),
    .rx_ready(1'b1), .rx_perr(perr1), .rx_ferr(ferr1), .rx_overrun(ovr1), .rx_busy(busy1)
`ifdef UART_RX_BREAK_DETECT_EN
    , .rx_break(brk1)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Monitor: counts deliveries, valid cycles and overrun pulses; captures each new word.
  int         deliv0 = 0, vcyc0 = 0, novr0 = 0, deliv1 = 0;
  logic       pv0 = 1'b0, pv1 = 1'b0;
  logic [7:0] cap_data0 = '0;
  logic       cap_perr0 = 1'b0, cap_ferr0 = 1'b0;
  logic [6:0] cap_data1 = '0;
  logic       cap_perr1 = 1'b0, cap_ferr1 = 1'b0;

  always @(negedge clk) begin
    pv0   <= valid0;
    pv1   <= valid1;
    vcyc0 <= vcyc0 + int'(valid0);
    novr0 <= novr0 + int'(ovr0);
    if (valid0 && !pv0) begin
      deliv0    <= deliv0 + 1;
      cap_data0 <= data0;
      cap_perr0 <= perr0;
      cap_ferr0 <= ferr0;
    end
    if (valid1 && !pv1) begin
      deliv1    <= deliv1 + 1;
      cap_data1 <= data1;
      cap_perr1 <= perr1;
      cap_ferr1 <= ferr1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input int line, input logic v);
    if (line == 0) din0 = v;
    else           din1 = v;
    tick(CPB);
  endtask

  task automatic send_frame(input int line, input int nbits, input logic [8:0] data,
                            input logic par, input logic stop2);
    drive_bit(line, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(line, data[i]);
    drive_bit(line, par);
    drive_bit(line, 1'b1);
    drive_bit(line, stop2);
  endtask

  task automatic idle(input int n);
    din0 = 1'b1;
    din1 = 1'b1;
    tick(n);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop2;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, v0, o0, d1;
    int waited;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};

    // Reset state
    tick(3);
    @(negedge clk);
    check("rst_valid", {31'b0, valid0}, 0);
    check("rst_busy", {31'b0, busy0}, 0);
    check("rst_data", {24'b0, data0}, 0);
    check("rst_flags", {29'b0, perr0, ferr0, ovr0}, 0);
    check("rst_dut1", {23'b0, data1, valid1, busy1}, 0);
    $display("reset: valid=%0b busy=%0b data=%0h", valid0, busy0, data0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(20);

    // 8E2 vector table with rx_ready held high
    for (int i = 0; i < 8; i++) begin
      d0 = deliv0;
      v0 = vcyc0;
      send_frame(0, 8, {1'b0, vecs[i].data}, vecs[i].par, vecs[i].stop2);
      idle(CPB);
      check("vec_deliv", 32'(deliv0 - d0), 1);
      check("vec_vcycles", 32'(vcyc0 - v0), 1);
      check("vec_data", {24'b0, cap_data0}, {24'b0, vecs[i].exp_data});
      check("vec_perr", {31'b0, cap_perr0}, {31'b0, vecs[i].exp_perr});
      check("vec_ferr", {31'b0, cap_ferr0}, {31'b0, vecs[i].exp_ferr});
      $display("vec %0d: sent=%0h rx_data=%0h perr=%0b ferr=%0b", i, vecs[i].data,
               cap_data0, cap_perr0, cap_ferr0);
    end

    // 7O2 instance: 0x55 has four ones so the odd parity bit is 1
    d1 = deliv1;
    send_frame(1, 7, 9'h055, 1'b1, 1'b1);
    idle(CPB);
    check("o7_deliv", 32'(deliv1 - d1), 1);
    check("o7_data", {25'b0, cap_data1}, 32'h55);
    check("o7_perr", {30'b0, cap_perr1, cap_ferr1}, 0);
    $display("7O2 good: rx_data=%0h perr=%0b ferr=%0b", cap_data1, cap_perr1, cap_ferr1);
    send_frame(1, 7, 9'h055, 1'b0, 1'b1);
    idle(CPB);
    check("o7_bad_data", {25'b0, cap_data1}, 32'h55);
    check("o7_bad_perr", {31'b0, cap_perr1}, 1);
    $display("7O2 bad parity: rx_data=%0h perr=%0b", cap_data1, cap_perr1);

    // Overrun: two back-to-back frames with rx_ready low
    ready0 = 1'b0;
    d0 = deliv0;
    o0 = novr0;
    send_frame(0, 8, 9'h011, 1'b0, 1'b1);
    send_frame(0, 8, 9'h022, 1'b0, 1'b1);
    idle(4);
    @(negedge clk);
    check("ovr_valid_held", {31'b0, valid0}, 1);
    check("ovr_data_held", {24'b0, data0}, 32'h11);
    check("ovr_pulses", 32'(novr0 - o0), 1);
    check("ovr_deliv", 32'(deliv0 - d0), 1);
    $display("overrun: data=%0h valid=%0b pulses=%0d", data0, valid0, novr0 - o0);
    @(posedge clk);
    #1 ready0 = 1'b1;
    @(posedge clk);
    #1 ready0 = 1'b0;
    @(negedge clk);
    check("ovr_accept_valid", {31'b0, valid0}, 0);
    ready0 = 1'b1;
    $display("accept: valid=%0b", valid0);
    idle(CPB);

    // Glitch: 5 low cycles must be rejected as a false start
    d0 = deliv0;
    din0 = 1'b0;
    tick(5);
    check("glitch_busy", {31'b0, busy0}, 1);
    din0 = 1'b1;
    waited = 0;
    while (busy0 && waited < CPB) begin
      tick(1);
      waited++;
    end
    check("glitch_idle", {31'b0, busy0}, 0);
    idle(2 * CPB);
    check("glitch_no_word", 32'(deliv0 - d0), 0);
    $display("glitch: busy cleared after %0d cycles", waited);

    // Reset in the middle of data bit 4 of 0x5A
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    din0 = 1'b1;
    tick(CPB / 2);
    check("mid_busy", {31'b0, busy0}, 1);
    d0 = deliv0;
    rst_n = 1'b0;
    din0 = 1'b1;
    tick(3);
    @(negedge clk);
    check("mid_rst_outs", {24'b0, data0}, 0);
    check("mid_rst_ctrl", {27'b0, valid0, perr0, ferr0, ovr0, busy0}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(20);
    check("mid_no_word", 32'(deliv0 - d0), 0);
    send_frame(0, 8, 9'h05A, 1'b0, 1'b1);
    idle(CPB);
    check("post_rst_deliv", 32'(deliv0 - d0), 1);
    check("post_rst_data", {24'b0, cap_data0}, 32'h5A);
    check("post_rst_flags", {30'b0, cap_perr0, cap_ferr0}, 0);
    $display("after reset: rx_data=%0h perr=%0b ferr=%0b", cap_data0, cap_perr0, cap_ferr0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
